// File: rtl/pixel_stream_pkg.sv
// rtl/pixel_stream_pkg.sv - shared types and constants for the pixel output link
//
// Purpose : transmitter FSM states, default pixel width and the supported
//           frame sizes (pixels per frame) of the pixel pipeline.
// Ports   : none (package).
package pixel_stream_pkg;

  localparam int DEFAULT_DATA_W = 8;

  // Frame sizes: Sobel output, first pooling stage, second pooling stage.
  localparam int PXL_CNT_SOBEL   = 3844;
  localparam int PXL_CNT_POOL_S1 = 3721;
  localparam int PXL_CNT_POOL_S2 = 961;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - MSB-first byte shifter with bit counter and last-bit strobe
//
// Purpose : holds one byte and presents it bit by bit, MSB first. A bit is
//           consumed when the shifter is loaded and advance_i is high.
// Ports   : clk_i/rst_ni   clock, asynchronous active-low reset
//           load_i         load load_data_i (wins over an emptying shift)
//           load_data_i    byte to transmit
//           advance_i      receiver accepts the current bit
//           valid_o        a byte is loaded (registered)
//           bit_o          current bit, 0 when not valid
//           byte_done_o    the last bit of the byte is consumed this cycle
module serial_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              advance_i,
  output logic              valid_o,
  output logic              bit_o,
  output logic              byte_done_o
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              loaded_q, loaded_d;
  logic              fire;

  assign fire        = loaded_q && advance_i;
  assign byte_done_o = fire && (bit_cnt_q == LAST_BIT);
  assign valid_o     = loaded_q;
  // Zeros shift in from the right, so the register is all-zero once a byte
  // drains; the gate keeps the line at 0 regardless.
  assign bit_o       = loaded_q && shift_q[DATA_W-1];

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    loaded_d  = loaded_q;
    if (fire) begin
      shift_d   = shift_q << 1;
      bit_cnt_d = bit_cnt_q + BW'(1);
      if (bit_cnt_q == LAST_BIT) begin
        loaded_d  = 1'b0;
        bit_cnt_d = '0;
      end
    end
    if (load_i) begin
      shift_d   = load_data_i;
      bit_cnt_d = '0;
      loaded_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      loaded_q  <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      loaded_q  <= loaded_d;
    end
  end

endmodule

// File: rtl/pixel_serial_tx.sv
// rtl/pixel_serial_tx.sv - frame-level pixel byte to serial bit transmitter
//
// Purpose : accepts PIXEL_CNT pixel bytes per frame over a valid/ready port,
//           serializes them MSB first on a valid/ready bit link and pulses
//           done when the last bit of the frame is taken.
// Ports   : clk_200mhz, reset_n (async, active-low)
//           start                     begin a frame (IDLE only)
//           pix_data/pix_valid/pix_ready   pixel input handshake
//           serial_data/serial_valid/serial_ready_in   bit output handshake
//           busy, done, pix_count     frame status
module pixel_serial_tx
  import pixel_stream_pkg::*;
#(
  parameter  int DATA_W    = DEFAULT_DATA_W,
  parameter  int PIXEL_CNT = PXL_CNT_POOL_S2,
  localparam int CNT_W     = $clog2(PIXEL_CNT + 1)
) (
  input  logic              clk_200mhz,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              serial_data,
  output logic              serial_valid,
  input  logic              serial_ready_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pix_count
);

  localparam logic [CNT_W-1:0] PIX_MAX  = CNT_W'(PIXEL_CNT);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXEL_CNT - 1);

  tx_state_e         state_q;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]  sent_cnt_q, sent_cnt_d;

  logic              accept, load_direct, sh_load, sh_valid, sh_bit, byte_done;
  logic [DATA_W-1:0] sh_load_data;

  // Depends on registered state only, never on the receiver side.
  assign pix_ready = (state_q == ST_RUN) && !hold_full_q && (acc_cnt_q < PIX_MAX);
  assign accept    = pix_valid && pix_ready;

  // A new byte goes straight to the shifter when it is free (or frees up this
  // cycle); accept and a full hold are mutually exclusive, so the hold byte
  // and the incoming byte never compete for the shifter.
  assign load_direct  = accept && (!sh_valid || byte_done);
  assign sh_load      = load_direct || (byte_done && hold_full_q);
  assign sh_load_data = hold_full_q ? hold_q : pix_data;

  serial_shifter #(
    .DATA_W(DATA_W)
  ) u_shifter (
    .clk_i       (clk_200mhz),
    .rst_ni      (reset_n),
    .load_i      (sh_load),
    .load_data_i (sh_load_data),
    .advance_i   (serial_ready_in),
    .valid_o     (sh_valid),
    .bit_o       (sh_bit),
    .byte_done_o (byte_done)
  );

  assign serial_valid = sh_valid;
  assign serial_data  = sh_bit;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pix_count    = sent_cnt_q;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    acc_cnt_d   = acc_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    if (state_q == ST_IDLE && start) begin
      acc_cnt_d   = '0;
      sent_cnt_d  = '0;
      hold_full_d = 1'b0;
    end else begin
      if (accept) begin
        acc_cnt_d = acc_cnt_q + CNT_W'(1);
        if (!load_direct) begin
          hold_d      = pix_data;
          hold_full_d = 1'b1;
        end
      end
      if (byte_done && hold_full_q) hold_full_d = 1'b0;
      if (byte_done && (sent_cnt_q < PIX_MAX)) sent_cnt_d = sent_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      acc_cnt_q   <= '0;
      sent_cnt_q  <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      acc_cnt_q   <= acc_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
    end
  end

  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          // The final byte completing is the same event as the sent counter
          // reaching PIXEL_CNT.
          if (byte_done && (sent_cnt_q == PIX_LAST)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_serial_tx.sv
// tb/tb_pixel_serial_tx.sv - self-checking bench for pixel_serial_tx
module tb_pixel_serial_tx;
  import pixel_stream_pkg::*;

  localparam int DW    = 8;
  localparam int NS    = 4;
  localparam int NL    = PXL_CNT_POOL_S2;
  localparam int CWS   = $clog2(NS + 1);
  localparam int CWL   = $clog2(NL + 1);

  logic clk_200mhz = 1'b0;
  logic reset_n, start, pix_valid, serial_ready_in;
  logic [DW-1:0] pix_data;

  logic pr_s, sd_s, sv_s, busy_s, done_s;
  logic [CWS-1:0] cnt_s;
  logic pr_l, sd_l, sv_l, busy_l, done_l;
  logic [CWL-1:0] cnt_l;

  logic sel = 1'b0;
  logic o_pr, o_sd, o_sv, o_busy, o_done;
  logic [31:0] o_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] src[$];
  logic       rx_bits[$];
  int r_fires, r_valid_cyc, r_gaps, r_done, r_acc, r_stab_err, r_ready_over;
  int r_idle_bit_err, r_last_fire_cyc, r_done_cyc;
  logic r_busy_at_done;
  logic [31:0] r_reset_outs, r_reset_cnt;

  pixel_serial_tx #(.DATA_W(DW), .PIXEL_CNT(NS)) dut_small (
    .clk_200mhz(clk_200mhz), .reset_n(reset_n), .start(start),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pr_s),
    .serial_data(sd_s), .serial_valid(sv_s), .serial_ready_in(serial_ready_in),
    .busy(busy_s), .done(done_s), .pix_count(cnt_s));

  pixel_serial_tx #(.DATA_W(DW), .PIXEL_CNT(NL)) dut_large (
    .clk_200mhz(clk_200mhz), .reset_n(reset_n), .start(start),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pr_l),
    .serial_data(sd_l), .serial_valid(sv_l), .serial_ready_in(serial_ready_in),
    .busy(busy_l), .done(done_l), .pix_count(cnt_l));

  initial forever #5 clk_200mhz = ~clk_200mhz;

  always_comb begin
    if (sel) begin
      o_pr = pr_l; o_sd = sd_l; o_sv = sv_l; o_busy = busy_l; o_done = done_l;
      o_cnt = 32'(cnt_l);
    end else begin
      o_pr = pr_s; o_sd = sd_s; o_sv = sv_s; o_busy = busy_s; o_done = done_s;
      o_cnt = 32'(cnt_s);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_200mhz);
    reset_n = 1'b0; start = 1'b0; pix_valid = 1'b0; serial_ready_in = 1'b0;
    repeat (2) @(negedge clk_200mhz);
    reset_n = 1'b1;
    @(negedge clk_200mhz);
  endtask

  // Drives one frame cycle by cycle. Handshakes are evaluated from outputs
  // sampled at the falling edge and the inputs chosen for the next rising edge.
  // rmode: 0 ready high, 1 ready 0/1 alternating over valid cycles, 2 random.
  // vmode: 0 valid while bytes remain, 1 one byte per 12 cycles, 2 random.
  task automatic run_frame(input int npix, input int rmode, input int vmode,
                           input int start_mid_cyc, input int reset_at, input int budget);
    int off, gap_wait, tog;
    logic prev_stall, prev_sv, prev_sd, rdy, pv, fire, acc;
    off = 0; gap_wait = 0; tog = 0;
    prev_stall = 1'b0; prev_sv = 1'b0; prev_sd = 1'b0;
    rx_bits.delete();
    r_fires = 0; r_valid_cyc = 0; r_gaps = 0; r_done = 0; r_acc = 0;
    r_stab_err = 0; r_ready_over = 0; r_idle_bit_err = 0;
    r_last_fire_cyc = -1; r_done_cyc = -1; r_busy_at_done = 1'b1;
    r_reset_outs = '1; r_reset_cnt = '1;
    @(negedge clk_200mhz);
    start = 1'b1; pix_valid = 1'b0; serial_ready_in = 1'b0;
    @(negedge clk_200mhz);
    start = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (prev_stall && (o_sv !== prev_sv || o_sd !== prev_sd)) r_stab_err++;
      if (!o_sv && o_sd !== 1'b0) r_idle_bit_err++;
      if (o_done) begin
        r_done++; r_done_cyc = cyc; r_busy_at_done = o_busy;
        break;
      end
      if (o_sv) r_valid_cyc++;
      else if (r_fires > 0 && o_busy) r_gaps++;
      if (o_pr && off >= npix) r_ready_over++;
      case (rmode)
        0: rdy = 1'b1;
        1: begin rdy = o_sv && (tog % 2 == 1); if (o_sv) tog++; end
        default: rdy = ($urandom_range(3) != 0);
      endcase
      case (vmode)
        0: pv = (off < src.size());
        1: pv = (off < src.size()) && (gap_wait == 0);
        default: pv = (off < src.size()) && ($urandom_range(1) == 1);
      endcase
      pix_data = (off < src.size()) ? src[off] : 8'($urandom);
      pix_valid = pv;
      serial_ready_in = rdy;
      start = (cyc == start_mid_cyc);
      fire = o_sv && rdy;
      acc = pv && o_pr;
      if (fire) begin rx_bits.push_back(o_sd); r_fires++; r_last_fire_cyc = cyc; end
      if (acc) begin off++; gap_wait = 11; end
      else if (gap_wait > 0) gap_wait--;
      prev_stall = o_sv && !rdy; prev_sv = o_sv; prev_sd = o_sd;
      @(posedge clk_200mhz);
      if (reset_at >= 0 && r_fires == reset_at) begin
        #2 reset_n = 1'b0;
        #1 r_reset_outs = 32'({o_pr, o_sd, o_sv, o_busy, o_done});
        r_reset_cnt = o_cnt;
        r_acc = off;
        pix_valid = 1'b0; serial_ready_in = 1'b0; start = 1'b0;
        @(negedge clk_200mhz);
        reset_n = 1'b1;
        return;
      end
      @(negedge clk_200mhz);
    end
    r_acc = off;
    pix_valid = 1'b0; serial_ready_in = 1'b0; start = 1'b0;
  endtask

  // Common end-of-frame checks; expected bit stream is the source bytes
  // concatenated MSB first.
  task automatic finish_frame(input string tag, input int npix);
    int extra_done, mism, n;
    logic exp_bits[$];
    extra_done = 0; mism = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_200mhz);
      if (o_done) extra_done++;
    end
    for (int p = 0; p < npix; p++)
      for (int b = DW - 1; b >= 0; b--) exp_bits.push_back(src[p][b]);
    n = (rx_bits.size() < exp_bits.size()) ? rx_bits.size() : exp_bits.size();
    for (int i = 0; i < n; i++) if (rx_bits[i] !== exp_bits[i]) mism++;
    check($sformatf("%s_done_pulses", tag), r_done + extra_done, 1);
    check($sformatf("%s_bit_count", tag), rx_bits.size(), npix * DW);
    check($sformatf("%s_bit_mismatches", tag), mism, 0);
    check($sformatf("%s_accepted", tag), r_acc, npix);
    check($sformatf("%s_pix_count", tag), o_cnt, npix);
    check($sformatf("%s_done_latency", tag), r_done_cyc - r_last_fire_cyc, 1);
    check($sformatf("%s_busy_at_done", tag), 32'(r_busy_at_done), 0);
    check($sformatf("%s_idle_outputs", tag), 32'({o_busy, o_pr, o_sv, o_done}), 0);
    check($sformatf("%s_stall_stable", tag), r_stab_err, 0);
    check($sformatf("%s_ready_beyond_frame", tag), r_ready_over, 0);
    check($sformatf("%s_data_zero_idle", tag), r_idle_bit_err, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; pix_valid = 1'b0; serial_ready_in = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk_200mhz);
    check("reset_small_outs", 32'({pr_s, sd_s, sv_s, busy_s, done_s}), 0);
    check("reset_small_count", 32'(cnt_s), 0);
    check("reset_large_outs", 32'({pr_l, sd_l, sv_l, busy_l, done_l}), 0);
    check("reset_large_count", 32'(cnt_l), 0);
    reset_n = 1'b1;
    @(negedge clk_200mhz);

    // Directed frame, receiver always ready: contiguous bits, fixed length.
    sel = 1'b0;
    src = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    run_frame(NS, 0, 0, -1, -1, 500);
    check("t1_valid_cycles", r_valid_cyc, NS * DW);
    check("t1_gaps", r_gaps, 0);
    check("t1_frame_cycles", r_done_cyc, NS * DW + 1);
    finish_frame("t1", NS);

    // Receiver ready alternating 0/1: same bits, twice the active cycles.
    run_frame(NS, 1, 0, -1, -1, 500);
    check("t2_valid_cycles", r_valid_cyc, 2 * NS * DW);
    check("t2_frame_cycles", r_done_cyc, 2 * NS * DW + 1);
    finish_frame("t2", NS);

    // One byte offered every 12 cycles: 4 idle link cycles between bytes.
    src = '{8'h81, 8'h7E, 8'h5A, 8'hC3};
    run_frame(NS, 0, 1, -1, -1, 500);
    check("t3_gaps", r_gaps, 4 * (NS - 1));
    finish_frame("t3", NS);

    // start pulsed mid-frame and a fifth byte kept on offer.
    src = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    run_frame(NS, 0, 0, 10, -1, 500);
    finish_frame("t4", NS);

    // Reset after 3 bits of the second byte, then a clean frame.
    src = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    run_frame(NS, 0, 0, -1, DW + 3, 500);
    check("t5_reset_outs", r_reset_outs, 0);
    check("t5_reset_count", r_reset_cnt, 0);
    @(negedge clk_200mhz);
    check("t5_after_reset_count", o_cnt, 0);
    src = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(NS, 2, 2, -1, -1, 2000);
    finish_frame("t5_clean", NS);

    // Random bytes with random valid and ready.
    for (int k = 0; k < 3; k++) begin
      src.delete();
      for (int i = 0; i < NS; i++) src.push_back(8'($urandom));
      run_frame(NS, 2, 2, -1, -1, 2000);
      finish_frame($sformatf("rnd%0d", k), NS);
    end

    // Full 961-pixel frame of incrementing bytes on the large instance.
    do_reset();
    sel = 1'b1;
    src.delete();
    for (int i = 0; i < NL; i++) src.push_back(8'(i % 256));
    run_frame(NL, 2, 2, -1, -1, 60000);
    check("t6_fires", r_fires, NL * DW);
    finish_frame("t6", NL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
